// File: rtl/hyperbus_burst_fifo.sv
// Single-clock HyperBus burst front-end: TX/RX word FIFOs plus MSB-first beat (de)serialiser.
// Optional flush input is compiled in when HBUS_FIFO_FLUSH_EN is defined.
module hyperbus_burst_fifo #(
  parameter int unsigned FIFO_DATA_WIDTH = 32,
  parameter int unsigned HBUS_DATA_WIDTH = 16,
  parameter int unsigned HBUS_ADDR_WIDTH = 32,
  parameter int unsigned DEPTH_LOG2      = 3,
  parameter int unsigned LEN_WIDTH       = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
`ifdef HBUS_FIFO_FLUSH_EN
  input  logic                       flush,
`endif
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_we,
  input  logic [HBUS_ADDR_WIDTH-1:0] cmd_adr,
  input  logic [LEN_WIDTH-1:0]       cmd_len,
  input  logic                       tx_valid,
  output logic                       tx_ready,
  input  logic [FIFO_DATA_WIDTH-1:0] tx_dat,
  output logic                       rx_valid,
  input  logic                       rx_ready,
  output logic [FIFO_DATA_WIDTH-1:0] rx_dat,
  output logic [HBUS_ADDR_WIDTH-1:0] hbus_adr_o,
  input  logic [HBUS_DATA_WIDTH-1:0] hbus_dat_i,
  output logic [HBUS_DATA_WIDTH-1:0] hbus_dat_o,
  output logic                       hbus_rrq,
  output logic                       hbus_wrq,
  input  logic                       hbus_ready,
  input  logic                       hbus_valid,
  input  logic                       hbus_busy,
  output logic                       busy
);

  localparam int unsigned Cycles = FIFO_DATA_WIDTH / HBUS_DATA_WIDTH;
  localparam int unsigned BeatW  = (Cycles > 1) ? $clog2(Cycles) : 1;
  localparam int unsigned CntW   = DEPTH_LOG2 + 1;
  localparam int unsigned WordsW = LEN_WIDTH + 1;
  localparam int unsigned Depth  = 2 ** DEPTH_LOG2;

  localparam logic [BeatW-1:0]      BeatMax = BeatW'(Cycles - 1);
  localparam logic [BeatW-1:0]      BeatOne = BeatW'(1);
  localparam logic [CntW-1:0]       CntFull = CntW'(Depth);
  localparam logic [CntW-1:0]       CntOne  = CntW'(1);
  localparam logic [DEPTH_LOG2-1:0] PtrOne  = DEPTH_LOG2'(1);
  localparam logic [WordsW-1:0]     WrdOne  = WordsW'(1);

  typedef enum logic [2:0] {StIdle, StWrWait, StWrite, StRdWait, StRead} state_e;

  state_e                     r_state;
  logic                       r_cmd_ready, r_wrq, r_rrq;
  logic [HBUS_ADDR_WIDTH-1:0] r_adr, r_cmd_adr;
  logic [WordsW-1:0]          r_words, r_words_left;
  logic [BeatW-1:0]           r_beat;
  logic [FIFO_DATA_WIDTH-1:0] r_shift, r_asm;

  logic [FIFO_DATA_WIDTH-1:0] r_tx_mem [Depth];
  logic [FIFO_DATA_WIDTH-1:0] r_rx_mem [Depth];
  logic [DEPTH_LOG2-1:0]      r_tx_wptr, r_tx_rptr, r_rx_wptr, r_rx_rptr;
  logic [CntW-1:0]            r_tx_count, r_rx_count;

  logic                       w_flush_now, w_flush_do, w_cmd_fire;
  logic                       w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
  logic                       w_wr_go, w_rd_go;
  logic [FIFO_DATA_WIDTH-1:0] w_tx_head, w_asm_next;

`ifdef HBUS_FIFO_FLUSH_EN
  logic r_flush_pend;

  // A flush requested mid-burst waits for IDLE so the burst is never truncated.
  always_ff @(posedge clk) begin
    if (!rst_n)          r_flush_pend <= 1'b0;
    else if (w_flush_do) r_flush_pend <= 1'b0;
    else if (flush)      r_flush_pend <= 1'b1;
  end

  assign w_flush_now = flush | r_flush_pend;
`else
  assign w_flush_now = 1'b0;
`endif

  assign w_flush_do = w_flush_now & (r_state == StIdle);

  assign cmd_ready  = r_cmd_ready & ~w_flush_do;
  assign w_cmd_fire = cmd_valid & cmd_ready;
  assign tx_ready   = (r_tx_count != CntFull);
  assign rx_valid   = (r_rx_count != '0);
  assign rx_dat     = r_rx_mem[r_rx_rptr];
  assign w_tx_head  = r_tx_mem[r_tx_rptr];
  assign w_tx_push  = tx_valid & tx_ready;
  assign w_rx_pop   = rx_valid & rx_ready;

  assign w_asm_next = (r_asm << HBUS_DATA_WIDTH) | FIFO_DATA_WIDTH'(hbus_dat_i);

  assign w_wr_go = ~hbus_busy & (r_tx_count >= CntW'(r_words));
  assign w_rd_go = ~hbus_busy & ((CntFull - r_rx_count) >= CntW'(r_words));

  assign w_tx_pop  = ((r_state == StWrWait) & w_wr_go) |
                     ((r_state == StWrite) & hbus_ready & (r_beat == '0) &
                      (r_words_left != '0));
  assign w_rx_push = (r_state == StRead) & hbus_valid & (r_beat == '0);

  assign hbus_adr_o = r_adr;
  assign hbus_dat_o = r_shift[FIFO_DATA_WIDTH-1 -: HBUS_DATA_WIDTH];
  assign hbus_wrq   = r_wrq;
  assign hbus_rrq   = r_rrq;
  assign busy       = (r_state != StIdle);

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wptr] <= tx_dat;
    if (w_rx_push) r_rx_mem[r_rx_wptr] <= w_asm_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || w_flush_do) begin
      r_tx_wptr  <= '0;
      r_tx_rptr  <= '0;
      r_tx_count <= '0;
      r_rx_wptr  <= '0;
      r_rx_rptr  <= '0;
      r_rx_count <= '0;
    end else begin
      if (w_tx_push) r_tx_wptr <= r_tx_wptr + PtrOne;
      if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + PtrOne;
      if (w_rx_push) r_rx_wptr <= r_rx_wptr + PtrOne;
      if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + PtrOne;
      if (w_tx_push && !w_tx_pop)      r_tx_count <= r_tx_count + CntOne;
      else if (!w_tx_push && w_tx_pop) r_tx_count <= r_tx_count - CntOne;
      if (w_rx_push && !w_rx_pop)      r_rx_count <= r_rx_count + CntOne;
      else if (!w_rx_push && w_rx_pop) r_rx_count <= r_rx_count - CntOne;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_cmd_ready  <= 1'b0;
      r_wrq        <= 1'b0;
      r_rrq        <= 1'b0;
      r_adr        <= '0;
      r_cmd_adr    <= '0;
      r_words      <= '0;
      r_words_left <= '0;
      r_beat       <= '0;
      r_shift      <= '0;
      r_asm        <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_cmd_fire) begin
            r_cmd_adr   <= cmd_adr;
            r_words     <= WordsW'(cmd_len) + WrdOne;
            r_cmd_ready <= 1'b0;
            r_state     <= cmd_we ? StWrWait : StRdWait;
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end
        StWrWait: begin
          if (w_wr_go) begin
            r_shift      <= w_tx_head;
            r_wrq        <= 1'b1;
            r_adr        <= r_cmd_adr;
            r_beat       <= BeatMax;
            r_words_left <= r_words - WrdOne;
            r_state      <= StWrite;
          end
        end
        StWrite: begin
          if (hbus_ready) begin
            if (r_beat != '0) begin
              r_shift <= r_shift << HBUS_DATA_WIDTH;
              r_beat  <= r_beat - BeatOne;
            end else if (r_words_left != '0) begin
              // Next word loads on the same edge as the last beat: no bubble.
              r_shift      <= w_tx_head;
              r_beat       <= BeatMax;
              r_words_left <= r_words_left - WrdOne;
            end else begin
              r_shift     <= r_shift << HBUS_DATA_WIDTH;
              r_wrq       <= 1'b0;
              r_cmd_ready <= 1'b1;
              r_state     <= StIdle;
            end
          end
        end
        StRdWait: begin
          if (w_rd_go) begin
            r_rrq        <= 1'b1;
            r_adr        <= r_cmd_adr;
            r_asm        <= '0;
            r_beat       <= BeatMax;
            r_words_left <= r_words;
            r_state      <= StRead;
          end
        end
        StRead: begin
          if (hbus_valid) begin
            r_asm <= w_asm_next;
            if (r_beat != '0) begin
              r_beat <= r_beat - BeatOne;
            end else begin
              r_beat       <= BeatMax;
              r_words_left <= r_words_left - WrdOne;
              if (r_words_left == WrdOne) begin
                r_rrq       <= 1'b0;
                r_cmd_ready <= 1'b1;
                r_state     <= StIdle;
              end
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_hyperbus_burst_fifo.sv
// Scoreboard bench for hyperbus_burst_fifo: stimulus queues expected beats/words/addresses,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_hyperbus_burst_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr;
  logic [2:0]  cmd_len;
  logic        tx_valid, tx_ready;
  logic [31:0] tx_dat;
  logic        rx_valid, rx_ready;
  logic [31:0] rx_dat;
  logic [31:0] hbus_adr_o;
  logic [15:0] hbus_dat_i, hbus_dat_o;
  logic        hbus_rrq, hbus_wrq, hbus_ready, hbus_valid, hbus_busy, busy;

  int checks = 0;
  int failures = 0;
  int wrq_cycles = 0;

  logic [15:0] exp_wr[$];
  logic [31:0] exp_rx[$];
  logic [31:0] exp_adr[$];

  hyperbus_burst_fifo dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_adr   (cmd_adr),
    .cmd_len   (cmd_len),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_dat    (tx_dat),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rx_dat    (rx_dat),
    .hbus_adr_o(hbus_adr_o),
    .hbus_dat_i(hbus_dat_i),
    .hbus_dat_o(hbus_dat_o),
    .hbus_rrq  (hbus_rrq),
    .hbus_wrq  (hbus_wrq),
    .hbus_ready(hbus_ready),
    .hbus_valid(hbus_valid),
    .hbus_busy (hbus_busy),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL %s: DUT output with no expected entry", name);
  endtask

  // Monitor: compares every presented beat/word/request address against the scoreboard.
  initial begin
    logic wrq_prev = 1'b0;
    logic rrq_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        wrq_prev = 1'b0;
        rrq_prev = 1'b0;
      end else begin
        if (hbus_wrq) wrq_cycles++;
        if ((hbus_wrq && !wrq_prev) || (hbus_rrq && !rrq_prev)) begin
          if (exp_adr.size() == 0) unexpected("hbus_adr_o");
          else check("hbus_adr_o", hbus_adr_o, exp_adr.pop_front());
        end
        if (hbus_wrq && hbus_ready) begin
          if (exp_wr.size() == 0) unexpected("hbus_dat_o");
          else check("hbus_dat_o", hbus_dat_o, exp_wr.pop_front());
        end
        if (rx_valid && rx_ready) begin
          if (exp_rx.size() == 0) unexpected("rx_dat");
          else check("rx_dat", rx_dat, exp_rx.pop_front());
        end
        wrq_prev = hbus_wrq;
        rrq_prev = hbus_rrq;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_word(input logic [31:0] d);
    exp_wr.push_back(d[31:16]);
    exp_wr.push_back(d[15:0]);
  endtask

  task automatic push_tx(input logic [31:0] d);
    int n = 0;
    tx_valid = 1'b1;
    tx_dat   = d;
    while (!tx_ready && n < 50) begin step(); n++; end
    if (!tx_ready) unexpected("push_tx_timeout");
    step();
    tx_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic we, input logic [31:0] adr, input logic [2:0] len);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_len   = len;
    exp_adr.push_back(adr);
    while (!cmd_ready && n < 50) begin step(); n++; end
    if (!cmd_ready) unexpected("cmd_handshake_timeout");
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_req(input logic wr, input string name);
    int n = 0;
    while (!(wr ? hbus_wrq : hbus_rrq) && n < 50) begin step(); n++; end
    check(name, wr ? hbus_wrq : hbus_rrq, 1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 300) begin step(); n++; end
    check({name, "_busy"}, busy, 0);
    check({name, "_cmd_ready"}, cmd_ready, 1);
  endtask

  task automatic feed(input logic [15:0] d, input int gap);
    hbus_valid = 1'b1;
    hbus_dat_i = d;
    step();
    hbus_valid = 1'b0;
    repeat (gap) step();
  endtask

  task automatic drain_rx(input string name);
    int n = 0;
    rx_ready = 1'b1;
    while (rx_valid && n < 40) begin step(); n++; end
    rx_ready = 1'b0;
    check({name, "_rx_empty"}, rx_valid, 0);
  endtask

  initial begin
    int   wr_start;
    logic saw;
    logic [15:0] a;

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_len = '0;
    tx_valid = 1'b0; tx_dat = '0; rx_ready = 1'b0; hbus_dat_i = '0;
    hbus_ready = 1'b0; hbus_valid = 1'b0; hbus_busy = 1'b0;

    // Reset state
    repeat (2) step();
    check("rst_rrq", hbus_rrq, 0);
    check("rst_wrq", hbus_wrq, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_adr", hbus_adr_o, 0);
    check("rst_dat_o", hbus_dat_o, 0);
    rst_n = 1'b1;
    step();
    check("post_rst_cmd_ready", cmd_ready, 1);

    // Write single word
    hbus_ready = 1'b1;
    push_tx(32'hA1B2C3D4);
    exp_word(32'hA1B2C3D4);
    wr_start = wrq_cycles;
    send_cmd(1'b1, 32'h100, 3'd0);
    wait_idle("wr1");
    check("wr1_wrq_cycles", wrq_cycles - wr_start, 2);

    // Stray hbus_valid in IDLE is ignored
    hbus_valid = 1'b1; hbus_dat_i = 16'hFFFF;
    repeat (2) step();
    hbus_valid = 1'b0;
    check("idle_valid_ignored", rx_valid, 0);

    // Read burst of 4 words with gaps
    exp_rx.push_back(32'h00010002);
    exp_rx.push_back(32'h00030004);
    exp_rx.push_back(32'h00050006);
    exp_rx.push_back(32'h00070008);
    send_cmd(1'b0, 32'h200, 3'd3);
    wait_req(1'b0, "rd4_rrq");
    for (int i = 1; i <= 8; i++) begin
      feed(16'(i), (i % 3 == 0) ? 1 : 0);
      if (i == 8) check("rd4_rrq_drop", hbus_rrq, 0);
      else if (i % 3 != 0) check("rd4_rrq_held", hbus_rrq, 1);
    end
    wait_idle("rd4");
    drain_rx("rd4");

    // Write gated on TX data
    push_tx(32'h11112222);
    push_tx(32'h33334444);
    exp_word(32'h11112222);
    exp_word(32'h33334444);
    exp_word(32'h55556666);
    wr_start = wrq_cycles;
    send_cmd(1'b1, 32'h300, 3'd2);
    saw = 1'b0;
    repeat (5) begin step(); saw |= hbus_wrq; end
    check("wr3_gated", saw, 0);
    push_tx(32'h55556666);
    wait_idle("wr3");
    check("wr3_wrq_cycles", wrq_cycles - wr_start, 6);

    // RX space and busy gating: fill RX with 7 words first
    for (int j = 0; j < 7; j++) begin
      a = 16'h0100 + 16'(2 * j);
      exp_rx.push_back({a, a + 16'h0001});
    end
    send_cmd(1'b0, 32'h380, 3'd6);
    wait_req(1'b0, "rd7_rrq");
    for (int k = 0; k < 14; k++) feed(16'h0100 + 16'(k), 0);
    wait_idle("rd7");
    exp_rx.push_back(32'hBEEF0001);
    exp_rx.push_back(32'hCAFE0002);
    hbus_busy = 1'b1;
    send_cmd(1'b0, 32'h400, 3'd1);
    saw = 1'b0;
    repeat (5) begin step(); saw |= hbus_rrq; end
    check("rrq_while_busy", saw, 0);
    hbus_busy = 1'b0;
    repeat (3) begin step(); saw |= hbus_rrq; end
    check("rrq_while_rx_full", saw, 0);
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    wait_req(1'b0, "rrq_after_pop");
    feed(16'hBEEF, 0);
    feed(16'h0001, 1);
    feed(16'hCAFE, 0);
    feed(16'h0002, 0);
    wait_idle("rd2");
    drain_rx("rd2");

    // FIFO boundaries: fill TX, then push/pop on the same edge during WRITE
    hbus_ready = 1'b0;
    for (int w = 0; w < 8; w++) begin
      push_tx(32'hC0DE0000 + 32'(w));
      exp_word(32'hC0DE0000 + 32'(w));
    end
    check("tx_full_ready", tx_ready, 0);
    tx_valid = 1'b1; tx_dat = 32'hDEADBEEF;
    repeat (2) step();
    tx_valid = 1'b0;
    check("tx_full_still", tx_ready, 0);
    send_cmd(1'b1, 32'h500, 3'd7);
    wait_req(1'b1, "wr8_wrq");
    check("tx_ready_after_first_pop", tx_ready, 1);
    hbus_ready = 1'b1;
    step();
    tx_valid = 1'b1; tx_dat = 32'h88888888;
    step();
    check("tx_push_pop_same_edge", tx_ready, 1);
    hbus_ready = 1'b0; tx_dat = 32'h99999999;
    step();
    check("tx_full_again", tx_ready, 0);
    tx_valid = 1'b0;
    hbus_ready = 1'b1;
    wait_idle("wr8");

    // Reset mid-burst
    send_cmd(1'b0, 32'h600, 3'd3);
    wait_req(1'b0, "rst_rd_rrq");
    feed(16'hAAAA, 0);
    feed(16'hBBBB, 0);
    feed(16'hCCCC, 0);
    check("pre_rst_rx_valid", rx_valid, 1);
    rst_n = 1'b0;
    step();
    check("mid_rst_rrq", hbus_rrq, 0);
    check("mid_rst_rx_valid", rx_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_tx_ready", tx_ready, 1);
    rst_n = 1'b1;
    repeat (2) step();
    check("after_rst_rx_valid", rx_valid, 0);
    check("after_rst_cmd_ready", cmd_ready, 1);

    check("exp_wr_left", exp_wr.size(), 0);
    check("exp_rx_left", exp_rx.size(), 0);
    check("exp_adr_left", exp_adr.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
